// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache.
// The core side is a single 64-bit word port. The memory side is a 512-bit
// line port to the arbiter. One access is in flight at a time. A miss first
// evicts a dirty victim, then fills the line, then completes the access.

// Per-word lane: merges the store word into one 64-bit slice of a line.
module dcache_lane #(
  parameter int VEC_W = 64
) (
  input  logic [VEC_W-1:0] base,
  input  logic [VEC_W-1:0] wdata,
  input  logic             wr,
  output logic [VEC_W-1:0] q
);
  assign q = wr ? wdata : base;
endmodule

module dcache_wb #(
  parameter int SETS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         wenable,
  input  logic [63:0]  addr,
  input  logic [63:0]  wdata,
  output logic [63:0]  rdata,
  output logic         done,
  output logic         drequest,
  input  logic         dreqack,
  output logic         dwrenable,
  output logic [63:0]  daddr,
  input  logic [511:0] drdata,
  output logic [511:0] dwdata,
  input  logic         ddone
);
  localparam int IDX_W     = $clog2(SETS);
  localparam int TAG_W     = 58 - IDX_W;
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 64;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_WB_WAIT, S_FILL_REQ, S_FILL_WAIT, S_RESP
  } state_e;

  state_e state, nxt;
  req_t   req;

  logic [NUM_LANES-1:0][VEC_W-1:0] data_mem [SETS];
  logic [TAG_W-1:0]                tag_mem  [SETS];
  logic [SETS-1:0]                 valid, dirty;

  logic [63:0]                     cur_addr, cur_wdata;
  logic                            cur_we;
  logic [IDX_W-1:0]                idx;
  logic [TAG_W-1:0]                tag;
  logic [2:0]                      wsel;
  logic                            hit;
  logic [NUM_LANES-1:0][VEC_W-1:0] base_line, new_line;
  logic                            hit_acc, fill_we, line_we;
  logic                            unused_lsb;

  // In IDLE the lookup runs on the live request so a hit completes in one
  // edge; afterwards everything works off the latched copy.
  assign cur_addr   = (state == S_IDLE) ? addr    : req.addr;
  assign cur_we     = (state == S_IDLE) ? wenable : req.we;
  assign cur_wdata  = (state == S_IDLE) ? wdata   : req.wdata;
  assign idx        = cur_addr[6+IDX_W-1:6];
  assign tag        = cur_addr[63:6+IDX_W];
  assign wsel       = cur_addr[5:3];
  assign unused_lsb = ^cur_addr[2:0];
  assign hit        = valid[idx] && (tag_mem[idx] == tag);

  // A fill merges the store into the incoming line; a hit merges into the
  // resident line.
  assign base_line = (state == S_FILL_WAIT) ? drdata : data_mem[idx];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dcache_lane #(.VEC_W(VEC_W)) u_lane (
      .base  (base_line[l]),
      .wdata (cur_wdata),
      .wr    (cur_we && (wsel == 3'(l))),
      .q     (new_line[l])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next state and array write strobes.
  always_comb begin
    nxt     = state;
    hit_acc = 1'b0;
    fill_we = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          if (hit) begin
            hit_acc = 1'b1;
            nxt     = S_RESP;
          end else if (valid[idx] && dirty[idx]) begin
            nxt = S_WB_REQ;
          end else begin
            nxt = S_FILL_REQ;
          end
        end
      end
      S_WB_REQ:    if (dreqack) nxt = S_WB_WAIT;
      S_WB_WAIT:   if (ddone)   nxt = S_FILL_REQ;
      S_FILL_REQ:  if (dreqack) nxt = S_FILL_WAIT;
      S_FILL_WAIT: begin
        if (ddone) begin
          fill_we = 1'b1;
          nxt     = S_RESP;
        end
      end
      S_RESP:      nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  assign line_we = (hit_acc && cur_we) || fill_we;

  // Latch the request at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset)                        req <= '0;
    else if (state == S_IDLE && enable) req <= '{we: wenable, addr: addr, wdata: wdata};
  end

  // Line data and tags carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (line_we) data_mem[idx] <= new_line;
    if (fill_we) tag_mem[idx]  <= tag;
  end

  // Valid/dirty bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (hit_acc && cur_we)             dirty[idx] <= 1'b1;
      if (state == S_WB_WAIT && ddone)   dirty[idx] <= 1'b0;
      if (fill_we) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= cur_we;
      end
    end
  end

  // Load data; for stores it just carries the written word.
  always_ff @(posedge clk) begin
    if (!reset)                  rdata <= '0;
    else if (hit_acc || fill_we) rdata <= new_line[wsel];
  end

  // Arbiter-side outputs decode from state; eviction fields stay stable
  // through WB_WAIT because the victim entry is untouched until the fill.
  always_comb begin
    done      = (state == S_RESP);
    drequest  = (state == S_WB_REQ) || (state == S_FILL_REQ);
    dwrenable = (state == S_WB_REQ) || (state == S_WB_WAIT);
    daddr     = '0;
    dwdata    = '0;
    if (dwrenable) begin
      daddr  = {tag_mem[idx], idx, 6'b0};
      dwdata = data_mem[idx];
    end else if (state == S_FILL_REQ || state == S_FILL_WAIT) begin
      daddr  = {req.addr[63:6], 6'b0};
    end
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: a flat-memory reference model predicts load
// data, and a line-residency model predicts arbiter traffic per access.
module tb_dcache_wb;
  localparam int SETS = 64;

  logic         clk = 1'b0, reset = 1'b0, enable = 1'b0, wenable = 1'b0;
  logic [63:0]  addr = '0, wdata = '0;
  logic [63:0]  rdata, daddr;
  logic         done, drequest, dwrenable;
  logic         dreqack = 1'b0, ddone = 1'b0;
  logic [511:0] drdata = '0, dwdata;

  dcache_wb #(.SETS(SETS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wenable(wenable),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
    .drequest(drequest), .dreqack(dreqack), .dwrenable(dwrenable),
    .daddr(daddr), .drdata(drdata), .dwdata(dwdata), .ddone(ddone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, failed = 0;

  typedef struct {
    bit        is_load;
    bit [63:0] exp_rd;
    bit        hit;
    bit        wb;
    bit [63:0] wb_addr;
    bit [63:0] fill_addr;
    int        issue;
  } exp_t;
  typedef struct {
    bit        we;
    bit [63:0] a;
  } xfer_t;

  exp_t      sbq[$];
  xfer_t     xlog[$];
  int        last_ddone = 0;
  bit [63:0]  refmem[bit [63:0]];
  bit [511:0] amem[bit [63:0]];
  bit [63:0] res_line[SETS];
  bit        res_v[SETS], res_d[SETS];
  int        ack_dly = 3, done_dly = 1;
  bit        arb_on = 1'b1;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  endtask

  // Memory contents never written by anyone.
  function automatic bit [63:0] backing(bit [63:0] a);
    if (a == 64'h1008) return 64'hDEAD_BEEF;
    return {a[31:0] ^ 32'h5EED_1234, ~a[31:0]};
  endfunction

  function automatic bit [511:0] mem_line(bit [63:0] la);
    bit [511:0] l;
    if (amem.exists(la)) return amem[la];
    for (int w = 0; w < 8; w++) l[w*64 +: 64] = backing(la + 64'(w * 8));
    return l;
  endfunction

  // Architectural view: last store to a word, else what memory holds.
  function automatic bit [63:0] ref_rd(bit [63:0] a);
    bit [63:0]  aa = {a[63:3], 3'b0};
    bit [511:0] l;
    int         w;
    if (refmem.exists(aa)) return refmem[aa];
    l = mem_line({aa[63:6], 6'b0});
    w = int'(aa[5:3]);
    return l[w*64 +: 64];
  endfunction

  function automatic bit [511:0] ref_line(bit [63:0] la);
    bit [511:0] l;
    for (int w = 0; w < 8; w++) l[w*64 +: 64] = ref_rd(la + 64'(w * 8));
    return l;
  endfunction

  function automatic exp_t predict(bit we, bit [63:0] a, bit [63:0] wd);
    exp_t      e;
    bit [63:0] la = {a[63:6], 6'b0};
    int        s  = int'((a >> 6) & 64'(SETS - 1));
    e.is_load   = !we;
    e.exp_rd    = ref_rd(a);
    e.hit       = res_v[s] && (res_line[s] == la);
    e.wb        = !e.hit && res_v[s] && res_d[s];
    e.wb_addr   = res_line[s];
    e.fill_addr = la;
    e.issue     = 0;
    if (!e.hit) begin
      res_line[s] = la;
      res_v[s]    = 1'b1;
      res_d[s]    = 1'b0;
    end
    if (we) begin
      res_d[s] = 1'b1;
      refmem[{a[63:3], 3'b0}] = wd;
    end
    return e;
  endfunction

  // Issue one access, then scramble the inputs to show they were latched.
  task automatic access(input bit we, input bit [63:0] a, input bit [63:0] wd);
    exp_t e;
    int   n = 0;
    enable = 1'b1; wenable = we; addr = a; wdata = wd;
    e = predict(we, a, wd);
    e.issue = cyc;
    sbq.push_back(e);
    @(negedge clk);
    enable = 1'b0; wenable = 1'($urandom);
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      tests++; failed++;
      $display("FAIL done_timeout: got no done expected done for addr %0h", a);
      finish_run();
    end
    // A request shown during the response cycle must be ignored.
    if ($urandom_range(0, 3) == 0) begin
      enable = 1'b1; wenable = 1'($urandom); addr = {$urandom, $urandom};
    end
    @(negedge clk);
    enable = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    int   n;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_done: got done=1 expected no access pending");
        end else begin
          e = sbq.pop_front();
          if (e.is_load) chk("rdata", rdata, e.exp_rd);
          n = e.hit ? 0 : (e.wb ? 2 : 1);
          chk("xfer_count", xlog.size(), n);
          if (xlog.size() == n && n > 0) begin
            if (e.wb) chk("wb_xfer", {xlog[0].we, xlog[0].a}, {1'b1, e.wb_addr});
            chk("fill_xfer", {xlog[n-1].we, xlog[n-1].a}, {1'b0, e.fill_addr});
          end
          if (e.hit) chk("hit_latency", cyc - e.issue, 1);
          else       chk("miss_latency", cyc - last_ddone, 1);
          xlog.delete();
        end
      end
    end
  end

  // Arbiter model with programmable or random handshake delays.
  initial begin
    xfer_t      x;
    bit [511:0] wl;
    int         d;
    @(negedge clk);
    forever begin
      if (arb_on && drequest === 1'b1) begin
        x.we = dwrenable; x.a = daddr; wl = dwdata;
        xlog.push_back(x);
        chk("daddr_align", daddr[5:0], 0);
        if (x.we) chk("wb_data", wl, ref_line(x.a));
        d = (ack_dly < 0) ? $urandom_range(0, 3) : ack_dly;
        repeat (d) @(negedge clk);
        chk("req_held", drequest, 1);
        dreqack = 1'b1;
        @(negedge clk);
        dreqack = 1'b0;
        chk("req_drop", drequest, 0);
        d = (done_dly < 0) ? $urandom_range(0, 3) : done_dly;
        repeat (d) @(negedge clk);
        if (x.we) begin
          chk("wb_hold", {dwrenable, daddr, dwdata}, {1'b1, x.a, wl});
          amem[x.a] = wl;
        end else begin
          drdata = mem_line(x.a);
        end
        ddone = 1'b1;
        last_ddone = cyc;
        @(negedge clk);
        ddone = 1'b0;
        drdata = {16{$urandom}};
      end else if (arb_on && $urandom_range(0, 7) == 0) begin
        dreqack = 1'b1; ddone = 1'b1; drdata = {16{32'hBADB_AD00}};
        @(negedge clk);
        dreqack = 1'b0; ddone = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin
    #500000;
    tests++; failed++;
    $display("FAIL global_timeout: got no end expected end of stimulus");
    finish_run();
  end

  // Stimulus.
  initial begin
    bit [63:0]  a;
    bit [511:0] l;
    int         n;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {done, drequest, dwrenable}, 0);
    chk("reset_data", {rdata, daddr}, 0);
    chk("reset_dwdata", dwdata, 0);
    reset = 1'b1;
    @(negedge clk);

    access(1'b0, 64'h1008, '0);
    access(1'b0, 64'h1008, '0);
    access(1'b1, 64'h1010, 64'h1234_5678_9ABC_DEF0);
    access(1'b0, 64'h1010, '0);
    access(1'b0, 64'h2008, '0);
    l = amem.exists(64'h1000) ? amem[64'h1000] : '0;
    chk("evicted_word2", l[191:128], 64'h1234_5678_9ABC_DEF0);
    access(1'b0, 64'h1000, '0);

    // Abandon a fill by resetting in FILL_WAIT.
    arb_on = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1; wenable = 1'b0; addr = 64'h3000;
    @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (drequest !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_fill_req", {drequest, dwrenable, daddr}, {1'b1, 1'b0, 64'h3000});
    dreqack = 1'b1;
    @(negedge clk);
    dreqack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {drequest, done, dwrenable, rdata, daddr}, 0);
    reset = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    chk("rst_no_done", n, 0);
    for (int s = 0; s < SETS; s++) begin
      res_v[s] = 1'b0;
      res_d[s] = 1'b0;
    end
    refmem.delete();
    arb_on = 1'b1;

    access(1'b0, 64'h2008, '0);

    // Random traffic over a few conflicting sets.
    ack_dly = -1; done_dly = -1;
    for (int i = 0; i < 400; i++) begin
      a = 64'($urandom_range(0, 3)) * 64'(SETS * 64)
        + 64'($urandom_range(0, 3) * 64 + $urandom_range(0, 7) * 8 + $urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) a[63] = 1'b1;
      access(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end
    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    finish_run();
  end
endmodule
